// File: rtl/fp32_mul_seq.sv
// Sequential binary32 multiplier: radix-2 shift-add significand product,
// round-to-nearest-even, IEEE exception flags, valid/ready on both sides.
module fp32_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        exc_invalid,
    output logic        exc_overflow,
    output logic        exc_underflow,
    output logic        exc_inexact
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [23:0] r_ma;
    logic [23:0] r_mb;
    logic [47:0] r_p;
    logic [4:0]  r_cnt;
    logic        r_special;
    logic [31:0] r_sp_y;
    logic        r_sp_inv;
    logic [31:0] r_y;
    logic        r_inv;
    logic        r_ovf;
    logic        r_unf;
    logic        r_inx;
    logic        r_out_valid;

    function automatic logic [5:0] lzc48(input logic [47:0] v);
        logic [5:0] n;
        logic       hit;
        n   = 6'd0;
        hit = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) begin
                    hit = 1'b1;
                end else begin
                    n = n + 6'd1;
                end
            end
        end
        return n;
    endfunction

    logic [7:0] w_a_exp;
    logic [7:0] w_b_exp;
    logic       w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic       w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic       w_special;
    logic       w_accept;

    assign w_a_exp   = a[30:23];
    assign w_b_exp   = b[30:23];
    assign w_a_nan   = (w_a_exp == 8'hff) & (a[22:0] != 23'd0);
    assign w_b_nan   = (w_b_exp == 8'hff) & (b[22:0] != 23'd0);
    assign w_a_inf   = (w_a_exp == 8'hff) & (a[22:0] == 23'd0);
    assign w_b_inf   = (w_b_exp == 8'hff) & (b[22:0] == 23'd0);
    assign w_a_zero  = (w_a_exp == 8'h00) & (a[22:0] == 23'd0);
    assign w_b_zero  = (w_b_exp == 8'h00) & (b[22:0] == 23'd0);
    assign w_a_snan  = w_a_nan & ~a[22];
    assign w_b_snan  = w_b_nan & ~b[22];
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign w_accept  = in_valid & in_ready;

    logic [31:0] w_sp_y;
    logic        w_sp_inv;

    // Special-operand result, resolved from the raw operands at accept time
    always_comb begin
        w_sp_y   = {a[31] ^ b[31], 31'd0};
        w_sp_inv = 1'b0;
        if (w_a_nan) begin
            w_sp_y   = {a[31], 8'hff, 1'b1, a[21:0]};
            w_sp_inv = w_a_snan | w_b_snan;
        end else if (w_b_nan) begin
            w_sp_y   = {b[31], 8'hff, 1'b1, b[21:0]};
            w_sp_inv = w_a_snan | w_b_snan;
        end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
            w_sp_y   = 32'h7fc00000;
            w_sp_inv = 1'b1;
        end else if (w_a_inf | w_b_inf) begin
            w_sp_y   = {a[31] ^ b[31], 8'hff, 23'd0};
            w_sp_inv = 1'b0;
        end else begin
            w_sp_y   = {a[31] ^ b[31], 31'd0};
            w_sp_inv = 1'b0;
        end
    end

    // One shift-add step: the multiplier is consumed LSB first from r_mb[0]
    logic [24:0] w_sum;
    logic [47:0] w_p_next;
    assign w_sum    = {1'b0, r_p[47:24]} + {1'b0, r_ma};
    assign w_p_next = r_mb[0] ? {w_sum, r_p[23:1]} : {1'b0, r_p[47:1]};

    logic [5:0]  w_lz;
    logic [47:0] w_q;
    logic [10:0] w_exp;
    logic        w_tiny;
    assign w_lz   = lzc48(r_p);
    assign w_q    = r_p << w_lz;
    assign w_exp  = {3'd0, r_ea} + {3'd0, r_eb} - 11'd126 - {5'd0, w_lz};
    assign w_tiny = w_exp[10] | (w_exp == 11'd0);

    // Normal rounding: adding 'up' into the packed exp/frac carries into the exponent on renormalization
    logic        w_n_g, w_n_s, w_n_up;
    logic [33:0] w_n_pack;
    logic [10:0] w_n_exp;
    assign w_n_g    = w_q[23];
    assign w_n_s    = |w_q[22:0];
    assign w_n_up   = w_n_g & (w_n_s | w_q[24]);
    assign w_n_pack = {w_exp, w_q[46:24]} + {33'd0, w_n_up};
    assign w_n_exp  = w_n_pack[33:23];

    logic [10:0] w_shamt;
    logic [4:0]  w_tsh;
    logic [47:0] w_t_q;
    logic [47:0] w_t_mask;
    logic        w_t_lost, w_t_g, w_t_s, w_t_up;
    logic [23:0] w_t_sum;
    assign w_shamt  = 11'd1 - w_exp;
    assign w_tsh    = (w_shamt > 11'd26) ? 5'd26 : w_shamt[4:0];
    assign w_t_q    = w_q >> w_tsh;
    assign w_t_mask = ~({48{1'b1}} << w_tsh);
    assign w_t_lost = |(w_q & w_t_mask);
    assign w_t_g    = w_t_q[23];
    assign w_t_s    = (|w_t_q[22:0]) | w_t_lost;
    assign w_t_up   = w_t_g & (w_t_s | w_t_q[24]);
    // A carry into bit 23 lands exactly on the min-normal encoding
    assign w_t_sum  = w_t_q[47:24] + {23'd0, w_t_up};

    logic [31:0] w_r_y;
    logic        w_r_inv, w_r_ovf, w_r_unf, w_r_inx;

    // Final result selection for the ROUND cycle
    always_comb begin
        w_r_y   = {r_sign, 31'd0};
        w_r_inv = 1'b0;
        w_r_ovf = 1'b0;
        w_r_unf = 1'b0;
        w_r_inx = 1'b0;
        if (r_special) begin
            w_r_y   = r_sp_y;
            w_r_inv = r_sp_inv;
        end else if (w_tiny) begin
            w_r_y   = {r_sign, 7'd0, w_t_sum};
            w_r_inx = w_t_g | w_t_s;
            w_r_unf = w_t_g | w_t_s;
        end else if (w_n_exp >= 11'd255) begin
            w_r_y   = {r_sign, 8'hff, 23'd0};
            w_r_ovf = 1'b1;
            w_r_inx = 1'b1;
        end else begin
            w_r_y   = {r_sign, w_n_exp[7:0], w_n_pack[22:0]};
            w_r_inx = w_n_g | w_n_s;
        end
    end

    // Next-state logic; specials skip the multiply loop
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_ROUND : S_MUL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MUL: begin
                if (r_cnt == 5'd23) begin
                    w_next = S_ROUND;
                end else begin
                    w_next = S_MUL;
                end
            end
            S_ROUND: w_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, multiply loop and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign      <= 1'b0;
            r_ea        <= 8'd0;
            r_eb        <= 8'd0;
            r_ma        <= 24'd0;
            r_mb        <= 24'd0;
            r_p         <= 48'd0;
            r_cnt       <= 5'd0;
            r_special   <= 1'b0;
            r_sp_y      <= 32'd0;
            r_sp_inv    <= 1'b0;
            r_y         <= 32'd0;
            r_inv       <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_inx       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign    <= a[31] ^ b[31];
                        r_ea      <= (w_a_exp == 8'd0) ? 8'd1 : w_a_exp;
                        r_eb      <= (w_b_exp == 8'd0) ? 8'd1 : w_b_exp;
                        r_ma      <= {(w_a_exp != 8'd0), a[22:0]};
                        r_mb      <= {(w_b_exp != 8'd0), b[22:0]};
                        r_p       <= 48'd0;
                        r_cnt     <= 5'd0;
                        r_special <= w_special;
                        r_sp_y    <= w_sp_y;
                        r_sp_inv  <= w_sp_inv;
                    end
                end
                S_MUL: begin
                    r_p   <= w_p_next;
                    r_mb  <= {1'b0, r_mb[23:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_ROUND: begin
                    r_y         <= w_r_y;
                    r_inv       <= w_r_inv;
                    r_ovf       <= w_r_ovf;
                    r_unf       <= w_r_unf;
                    r_inx       <= w_r_inx;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign y             = r_y;
    assign exc_invalid   = r_inv;
    assign exc_overflow  = r_ovf;
    assign exc_underflow = r_unf;
    assign exc_inexact   = r_inx;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed self-checking bench for fp32_mul_seq.
module tb_fp32_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        exc_invalid, exc_overflow, exc_underflow, exc_inexact;

    int checks = 0;
    int errors = 0;

    fp32_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .exc_invalid(exc_invalid), .exc_overflow(exc_overflow),
        .exc_underflow(exc_underflow), .exc_inexact(exc_inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // flags packed as {invalid, overflow, underflow, inexact}
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         output logic [31:0] ry, output logic [3:0] rf, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hdeadbeef;
        b = 32'h12345678;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        ry = y;
        rf = {exc_invalid, exc_overflow, exc_underflow, exc_inexact};
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h exp 00000000", y); end
        checks++;
        if ({exc_invalid, exc_overflow, exc_underflow, exc_inexact} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {exc_invalid, exc_overflow, exc_underflow, exc_inexact});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_normal();
        logic [31:0] ry; logic [3:0] rf; int lat;
        logic [31:0] va [4] = '{32'h3fc00000, 32'hbfc00000, 32'h3f800001, 32'h3f800001};
        logic [31:0] vb [4] = '{32'h40000000, 32'h40000000, 32'h3fc00000, 32'h3f800001};
        logic [31:0] vy [4] = '{32'h40400000, 32'hc0400000, 32'h3fc00002, 32'h3f800002};
        logic [3:0]  vf [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], ry, rf, lat);
            checks++;
            if (ry !== vy[i]) begin errors++; $display("FAIL normal%0d_y got %h exp %h", i, ry, vy[i]); end
            checks++;
            if (rf !== vf[i]) begin errors++; $display("FAIL normal%0d_flags got %b exp %b", i, rf, vf[i]); end
            checks++;
            if (lat !== 25) begin errors++; $display("FAIL normal%0d_latency got %0d exp 25", i, lat); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ry; logic [3:0] rf; int lat;
        do_op(32'h7f7fffff, 32'h40000000, ry, rf, lat);
        checks++;
        if (ry !== 32'h7f800000) begin errors++; $display("FAIL overflow_y got %h exp 7f800000", ry); end
        checks++;
        if (rf !== 4'b0101) begin errors++; $display("FAIL overflow_flags got %b exp 0101", rf); end
        checks++;
        if (lat !== 25) begin errors++; $display("FAIL overflow_latency got %0d exp 25", lat); end
    endtask

    task automatic test_special();
        logic [31:0] ry; logic [3:0] rf; int lat;
        logic [31:0] va [5] = '{32'h7f800000, 32'h7f800001, 32'h3f800000, 32'h7f800000, 32'h00000000};
        logic [31:0] vb [5] = '{32'h00000000, 32'h3f800000, 32'h7fc00001, 32'hc0000000, 32'hc0400000};
        logic [31:0] vy [5] = '{32'h7fc00000, 32'h7fc00001, 32'h7fc00001, 32'hff800000, 32'h80000000};
        logic [3:0]  vf [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], ry, rf, lat);
            checks++;
            if (ry !== vy[i]) begin errors++; $display("FAIL special%0d_y got %h exp %h", i, ry, vy[i]); end
            checks++;
            if (rf !== vf[i]) begin errors++; $display("FAIL special%0d_flags got %b exp %b", i, rf, vf[i]); end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL special%0d_latency got %0d exp 1", i, lat); end
        end
    endtask

    task automatic test_subnormal();
        logic [31:0] ry; logic [3:0] rf; int lat;
        do_op(32'h00800000, 32'h3f000000, ry, rf, lat);
        checks++;
        if (ry !== 32'h00400000) begin errors++; $display("FAIL sub_exact_y got %h exp 00400000", ry); end
        checks++;
        if (rf !== 4'b0000) begin errors++; $display("FAIL sub_exact_flags got %b exp 0000", rf); end
        do_op(32'h00800001, 32'h3f000000, ry, rf, lat);
        checks++;
        if (ry !== 32'h00400000) begin errors++; $display("FAIL sub_tie_y got %h exp 00400000", ry); end
        checks++;
        if (rf !== 4'b0011) begin errors++; $display("FAIL sub_tie_flags got %b exp 0011", rf); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a = 32'h3fc00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 100 && !out_valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 25) begin errors++; $display("FAIL bp_latency got %0d exp 25", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d valid/ready got %b%b exp 10", i, out_valid, in_ready);
            end
            checks++;
            if (y !== 32'h40400000 || {exc_invalid, exc_overflow, exc_underflow, exc_inexact} !== 4'b0000) begin
                errors++; $display("FAIL bp_hold%0d y got %h exp 40400000", i, y);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] ry; logic [3:0] rf; int lat;
        logic seen;
        @(negedge clk);
        a = 32'h3fc00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_during got %b exp 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready_after got %b exp 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_abandoned_valid got %b exp 0", seen); end
        do_op(32'h40000000, 32'h40400000, ry, rf, lat);
        checks++;
        if (ry !== 32'h40c00000) begin errors++; $display("FAIL midrst_next_y got %h exp 40c00000", ry); end
        checks++;
        if (rf !== 4'b0000) begin errors++; $display("FAIL midrst_next_flags got %b exp 0000", rf); end
        checks++;
        if (lat !== 25) begin errors++; $display("FAIL midrst_next_latency got %0d exp 25", lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_overflow();
        test_special();
        test_subnormal();
        test_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
